// File: rtl/prefetch_instruction_memory.sv
// -----------------------------------------------------------------------------
// prefetch_instruction_memory
//
// Word-addressed instruction memory with a small prefetch buffer in front of
// it. A fetch engine walks fetch_pc forward by 4 every cycle. It pushes
// {instruction, address, fault} entries into a circular FIFO. A consumer
// drains the FIFO with a valid/ready handshake.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   load_valid/ready      program-load write port (byte address + data word)
//   load_address/data     word to store; invalid addresses are dropped
//   redirect_valid        one-cycle pulse that restarts fetch at
//   redirect_address        redirect_address
//   out_valid/ready       head-of-buffer handshake
//   out_instruction       head entry instruction word (0 when not valid)
//   out_address           head entry byte address (0 when not valid)
//   out_fault             head entry was misaligned/out of range
//
// Edge priority is reset > redirect > load > fetch. Redirects and accepted
// loads both flush the buffer, and no fetch happens on those edges.
// -----------------------------------------------------------------------------
module prefetch_instruction_memory #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH         = 64,
  parameter int                    FIFO_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_address,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  out_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // An address is usable only if it is word aligned and its word index
  // lands inside the array. In other words, every bit above the index is zero.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a[ADDR_WIDTH-1:IDX_W+2] == '0);
  endfunction

  // Program memory powers up as zero and is deliberately left out of reset.
  // This lets a loaded program survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic                  fifo_fault [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  head_valid;
  logic                  load_accept;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  pc_ok;
  logic [DATA_WIDTH-1:0] fetch_word;

  // Handshake and control decode. A push is allowed into a full buffer
  // only when the head leaves on the same edge. Flush edges never push.
  always_comb begin
    load_ready  = reset_n && !redirect_valid;
    head_valid  = (count != '0);
    load_accept = load_valid && load_ready;
    pop         = head_valid && out_ready;
    flush       = redirect_valid || load_accept;
    push        = !flush && ((count != FULL_COUNT) || pop);
    pc_ok       = addr_ok(fetch_pc);
    fetch_word  = pc_ok ? mem[fetch_pc[IDX_W+1:2]] : '0;
  end

  // Head outputs are forced to zero whenever the buffer is empty.
  always_comb begin
    out_valid       = head_valid;
    out_instruction = head_valid ? fifo_instr[rd_ptr] : '0;
    out_address     = head_valid ? fifo_addr[rd_ptr]  : '0;
    out_fault       = head_valid ? fifo_fault[rd_ptr] : 1'b0;
  end

  // Program-load writes. Out-of-range or misaligned loads still flush the
  // buffer, but they leave the array untouched.
  always_ff @(posedge clock) begin
    if (load_accept && addr_ok(load_address)) begin
      mem[load_address[IDX_W+1:2]] <= load_data;
    end
  end

  // Buffer storage. Entry contents need no reset because the pointers and
  // count decide what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= fetch_word;
      fifo_addr[wr_ptr]  <= fetch_pc;
      fifo_fault[wr_ptr] <= !pc_ok;
    end
  end

  // Fetch pointer and FIFO bookkeeping. A load restarts fetch at the
  // current head so that every refetched word reflects the new contents.
  // If the head was popped on this same edge, the consumer keeps it and
  // the refetch delivers that address again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_ADDRESS;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_address;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (load_accept) begin
      if (head_valid) begin
        fetch_pc <= fifo_addr[rd_ptr];
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
